pwm_clock_divider: RTL and testbench
====================================

Name: pwm_clock_divider

Overview:
Parametrised clock-enable generator that feeds the PWM channels of the RGBW controller. It replaces the fixed divide-by-2 prescaler. The divisor is run-time programmable, with glitch-free reload at period boundaries, and the block can be restarted synchronously. It provides a one-cycle tick (clock enable) for downstream logic, a 50%-style toggled divided clock, and the live count value for phase alignment.

Parameters:
WIDTH, 8, width of divisor and counter in bits (>=2).
DIV_RESET, 0, divisor value loaded into the active register at reset (must fit in WIDTH).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  reset, synchronous, active-high.
en  input  1  count enable; when low, the counter and clk_out hold.
restart  input  1  synchronous restart: clears the phase and applies the pending divisor immediately.
div_in  input  WIDTH  new divisor value.
div_load  input  1  one-cycle strobe; captures div_in into the shadow register.
div_pending  output  1  shadow holds a divisor not yet applied.
tick  output  1  registered one-cycle pulse, once per period.
clk_out  output  1  registered divided clock; toggles once per period.
cnt  output  WIDTH  current counter value (0..div_active).

Behaviour:
- Registers: cnt, div_active, div_shadow, div_pending, tick, clk_out.
- Reset values: cnt=0, div_active=DIV_RESET, div_shadow=DIV_RESET, div_pending=0, tick=0, clk_out=0.
- Period = div_active+1 enabled cycles.
  - tick pulse rate = f_clk/(div_active+1) while en=1.
  - clk_out frequency = f_clk/(2*(div_active+1)).
- Priority: reset > restart > wrap/count > hold.
- Normal operation, en=1, cnt!=div_active:
  - cnt<=cnt+1, tick<=0.
- Wrap, en=1, cnt==div_active:
  - cnt<=0, tick<=1 (high exactly the following cycle), clk_out<=~clk_out.
  - If div_pending=1: div_active<=div_shadow, div_pending<=0.
- en=0: cnt, clk_out, div_active hold; tick<=0. No wrap occurs while disabled.
- div_load=1 without a wrap in the same cycle: div_shadow<=div_in, div_pending<=1.
  - Multiple loads before a wrap: the last value wins.
- div_load coincident with a wrap: div_in is applied directly (div_active<=div_in), div_shadow<=div_in, div_pending<=0.
- restart=1 (with or without en):
  - cnt<=0, clk_out<=0, tick<=0.
  - If div_load is also high: div_active<=div_in. Otherwise, if pending: div_active<=div_shadow.
  - div_pending<=0 in either case.
- Divisor 0: wraps every enabled cycle.
  - tick stays high continuously.
  - clk_out toggles every cycle (f_clk/2, the legacy prescaler behaviour).
- Divisor 2^WIDTH-1: cnt reaches the all-ones value then wraps to 0. No overflow beyond div_active is possible.
- Divisor reduced below the current cnt: cannot occur, because reload happens only at a wrap or restart, where cnt=0.
- Mid-operation reset: all registers return to their reset values on the next edge, regardless of en, restart or div_load.
- No combinational path from inputs to outputs. All outputs are registered, with latency 1 cycle from the causing edge.

Test Plan:
- Reset, DIV_RESET=0, en=1 -> tick held 1 every cycle; clk_out toggles every cycle; cnt stays 0.
- Load 3 via div_load, then let the old period wrap -> div_pending=1 until that wrap.
  - Afterwards tick is high 1 cycle in every 4.
  - clk_out period is 8 cycles; cnt sequence is 0,1,2,3,0.
- en deasserted at cnt=2 for 5 cycles with div=3 -> cnt holds 2; tick=0; clk_out unchanged.
  - On re-enable the sequence resumes at 3 and then wraps.
- div_load=1 with div_in=5 in the same cycle as a wrap at div=3 -> next period is 6 cycles; div_pending never asserts.
- restart=1 at cnt=4 with div=7 and a pending shadow of 1 -> cnt=0, clk_out=0 next cycle.
  - div_active becomes 1, so tick follows on every 2nd cycle; div_pending=0.
- WIDTH=4, div=15, plus assertion of reset mid-period -> cnt wraps at 15 to 0 with no overflow.
  - reset mid-period forces cnt=0, tick=0, clk_out=0, div_active=DIV_RESET on the next edge.

Source files
------------

// File: rtl/pwm_clock_divider.sv
// pwm_clock_divider
// Programmable clock-enable generator for the RGBW PWM channels.
// A counter runs 0..div_active and wraps, so one period is div_active+1
// enabled cycles. Each wrap produces a one-cycle tick and toggles clk_out.
// A new divisor is held in a shadow register and applied only at a period
// boundary (wrap) or on a synchronous restart, so the output never glitches.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-high reset
//   en          count enable; counter and clk_out hold while low
//   restart     synchronous restart: phase cleared, pending divisor applied
//   div_in      new divisor value
//   div_load    one-cycle strobe capturing div_in into the shadow register
//   div_pending shadow holds a divisor that has not been applied yet
//   tick        one-cycle pulse per period
//   clk_out     divided clock, toggles once per period
//   cnt         live counter value, for phase alignment
module pwm_clock_divider #(
  parameter int WIDTH     = 8,
  parameter int DIV_RESET = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             restart,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             div_pending,
  output logic             tick,
  output logic             clk_out,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] DIV_INIT = WIDTH'(DIV_RESET);
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_ZERO = '0;

  logic [WIDTH-1:0] cnt_r;
  logic [WIDTH-1:0] div_active_r;
  logic [WIDTH-1:0] div_shadow_r;
  logic             div_pending_r;
  logic             tick_r;
  logic             clk_out_r;
  logic             wrap_s;

  // A wrap only happens on an enabled cycle at the end of the period.
  always_comb begin
    wrap_s = 1'b0;
    if (en && (cnt_r == div_active_r)) begin
      wrap_s = 1'b1;
    end else begin
      wrap_s = 1'b0;
    end
  end

  // Counter, divisor reload and output state.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r         <= CNT_ZERO;
      div_active_r  <= DIV_INIT;
      div_shadow_r  <= DIV_INIT;
      div_pending_r <= 1'b0;
      tick_r        <= 1'b0;
      clk_out_r     <= 1'b0;
    end else if (restart) begin
      cnt_r         <= CNT_ZERO;
      clk_out_r     <= 1'b0;
      tick_r        <= 1'b0;
      div_pending_r <= 1'b0;
      // A coincident load wins over an older pending value.
      if (div_load) begin
        div_active_r <= div_in;
        div_shadow_r <= div_in;
      end else if (div_pending_r) begin
        div_active_r <= div_shadow_r;
      end else begin
        div_active_r <= div_active_r;
      end
    end else if (wrap_s) begin
      cnt_r     <= CNT_ZERO;
      tick_r    <= 1'b1;
      clk_out_r <= ~clk_out_r;
      // At a period boundary a coincident load is applied directly and
      // never shows up as pending.
      if (div_load) begin
        div_active_r  <= div_in;
        div_shadow_r  <= div_in;
        div_pending_r <= 1'b0;
      end else if (div_pending_r) begin
        div_active_r  <= div_shadow_r;
        div_pending_r <= 1'b0;
      end else begin
        div_pending_r <= 1'b0;
      end
    end else begin
      tick_r <= 1'b0;
      if (en) begin
        cnt_r <= cnt_r + CNT_ONE;
      end else begin
        cnt_r <= cnt_r;
      end
      // Mid-period loads are parked in the shadow; the last one wins.
      if (div_load) begin
        div_shadow_r  <= div_in;
        div_pending_r <= 1'b1;
      end else begin
        div_pending_r <= div_pending_r;
      end
    end
  end

  assign cnt         = cnt_r;
  assign tick        = tick_r;
  assign clk_out     = clk_out_r;
  assign div_pending = div_pending_r;

endmodule

// File: tb/tb_pwm_clock_divider.sv
module tb_pwm_clock_divider;

  logic       clk;
  logic       reset, en, restart, div_load;
  logic [7:0] div_in;
  logic       div_pending, tick, clk_out;
  logic [7:0] cnt;

  logic       reset4, en4, restart4, div_load4;
  logic [3:0] div_in4;
  logic       div_pending4, tick4, clk_out4;
  logic [3:0] cnt4;

  int n_checks = 0;
  int n_fail   = 0;
  logic exp_clk;

  pwm_clock_divider #(.WIDTH(8), .DIV_RESET(0)) dut (
    .clk(clk), .reset(reset), .en(en), .restart(restart),
    .div_in(div_in), .div_load(div_load), .div_pending(div_pending),
    .tick(tick), .clk_out(clk_out), .cnt(cnt)
  );

  pwm_clock_divider #(.WIDTH(4), .DIV_RESET(2)) dut4 (
    .clk(clk), .reset(reset4), .en(en4), .restart(restart4),
    .div_in(div_in4), .div_load(div_load4), .div_pending(div_pending4),
    .tick(tick4), .clk_out(clk_out4), .cnt(cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; restart = 1'b0; div_load = 1'b0; div_in = 8'd0;
    reset4 = 1'b1; en4 = 1'b0; restart4 = 1'b0; div_load4 = 1'b0; div_in4 = 4'd0;
    cyc(); cyc();
    n_checks++; if (cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", cnt); end
    n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b expected 0", tick); end
    n_checks++; if (clk_out !== 1'b0) begin n_fail++; $display("FAIL reset_clk_out: got %b expected 0", clk_out); end
    n_checks++; if (div_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %b expected 0", div_pending); end
    reset = 1'b0;
  endtask

  // Divisor 0: tick stuck high, clk_out toggles every cycle, cnt stays 0.
  task automatic test_div_zero();
    for (int i = 1; i <= 4; i++) begin
      cyc();
      n_checks++; if (tick !== 1'b1) begin n_fail++; $display("FAIL div0_tick[%0d]: got %b expected 1", i, tick); end
      n_checks++; if (cnt !== 8'd0) begin n_fail++; $display("FAIL div0_cnt[%0d]: got %0d expected 0", i, cnt); end
      n_checks++; if (clk_out !== 1'(i % 2)) begin n_fail++; $display("FAIL div0_clk_out[%0d]: got %b expected %0d", i, clk_out, i % 2); end
    end
    exp_clk = 1'b0;
  endtask

  // Loads while disabled stay pending (last wins) until the next wrap.
  task automatic test_load_pending();
    en = 1'b0;
    cyc();
    n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL dis_tick: got %b expected 0", tick); end
    div_in = 8'd9; div_load = 1'b1; cyc();
    div_in = 8'd3; cyc();
    div_load = 1'b0;
    n_checks++; if (div_pending !== 1'b1) begin n_fail++; $display("FAIL load_pending: got %b expected 1", div_pending); end
    n_checks++; if (cnt !== 8'd0) begin n_fail++; $display("FAIL load_cnt: got %0d expected 0", cnt); end
    en = 1'b1;
    cyc();
    exp_clk = ~exp_clk;
    n_checks++; if (div_pending !== 1'b0) begin n_fail++; $display("FAIL load_applied: got %b expected 0", div_pending); end
    n_checks++; if (tick !== 1'b1) begin n_fail++; $display("FAIL load_wrap_tick: got %b expected 1", tick); end
    for (int i = 1; i <= 8; i++) begin
      cyc();
      if (i % 4 == 0) exp_clk = ~exp_clk;
      n_checks++; if (cnt !== 8'(i % 4)) begin n_fail++; $display("FAIL div3_cnt[%0d]: got %0d expected %0d", i, cnt, i % 4); end
      n_checks++; if (tick !== (i % 4 == 0)) begin n_fail++; $display("FAIL div3_tick[%0d]: got %b expected %b", i, tick, (i % 4 == 0)); end
      n_checks++; if (clk_out !== exp_clk) begin n_fail++; $display("FAIL div3_clk_out[%0d]: got %b expected %b", i, clk_out, exp_clk); end
    end
  endtask

  // en low at cnt=2 freezes everything for 5 cycles, then resumes.
  task automatic test_enable_hold();
    cyc(); cyc();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      n_checks++; if (cnt !== 8'd2) begin n_fail++; $display("FAIL hold_cnt[%0d]: got %0d expected 2", i, cnt); end
      n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL hold_tick[%0d]: got %b expected 0", i, tick); end
      n_checks++; if (clk_out !== exp_clk) begin n_fail++; $display("FAIL hold_clk_out[%0d]: got %b expected %b", i, clk_out, exp_clk); end
    end
    en = 1'b1;
    cyc();
    n_checks++; if (cnt !== 8'd3) begin n_fail++; $display("FAIL resume_cnt: got %0d expected 3", cnt); end
    cyc();
    exp_clk = ~exp_clk;
    n_checks++; if (cnt !== 8'd0 || tick !== 1'b1) begin n_fail++; $display("FAIL resume_wrap: got cnt=%0d tick=%b expected cnt=0 tick=1", cnt, tick); end
    n_checks++; if (clk_out !== exp_clk) begin n_fail++; $display("FAIL resume_clk_out: got %b expected %b", clk_out, exp_clk); end
  endtask

  // Load coincident with a wrap is applied directly, never pending.
  task automatic test_load_on_wrap();
    cyc(); cyc(); cyc();
    n_checks++; if (cnt !== 8'd3) begin n_fail++; $display("FAIL pre_wrap_cnt: got %0d expected 3", cnt); end
    div_in = 8'd5; div_load = 1'b1;
    cyc();
    div_load = 1'b0;
    exp_clk = ~exp_clk;
    n_checks++; if (tick !== 1'b1 || div_pending !== 1'b0) begin n_fail++; $display("FAIL wrap_load: got tick=%b pending=%b expected tick=1 pending=0", tick, div_pending); end
    for (int i = 1; i <= 6; i++) begin
      cyc();
      n_checks++; if (cnt !== 8'(i % 6)) begin n_fail++; $display("FAIL div5_cnt[%0d]: got %0d expected %0d", i, cnt, i % 6); end
      n_checks++; if (tick !== (i == 6)) begin n_fail++; $display("FAIL div5_tick[%0d]: got %b expected %b", i, tick, (i == 6)); end
      n_checks++; if (div_pending !== 1'b0) begin n_fail++; $display("FAIL div5_pending[%0d]: got %b expected 0", i, div_pending); end
    end
    exp_clk = ~exp_clk;
  endtask

  // Restart at cnt=4, div=7, pending shadow 1: phase cleared, div becomes 1.
  task automatic test_restart();
    div_in = 8'd7; div_load = 1'b1;
    cyc();
    div_load = 1'b0;
    n_checks++; if (div_pending !== 1'b1 || cnt !== 8'd1) begin n_fail++; $display("FAIL rs_load7: got pending=%b cnt=%0d expected pending=1 cnt=1", div_pending, cnt); end
    repeat (5) cyc();
    n_checks++; if (cnt !== 8'd0 || tick !== 1'b1 || div_pending !== 1'b0) begin n_fail++; $display("FAIL rs_wrap5: got cnt=%0d tick=%b pending=%b expected 0 1 0", cnt, tick, div_pending); end
    repeat (3) cyc();
    div_in = 8'd1; div_load = 1'b1;
    cyc();
    div_load = 1'b0;
    n_checks++; if (cnt !== 8'd4 || div_pending !== 1'b1) begin n_fail++; $display("FAIL rs_pre: got cnt=%0d pending=%b expected cnt=4 pending=1", cnt, div_pending); end
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    n_checks++; if (cnt !== 8'd0) begin n_fail++; $display("FAIL rs_cnt: got %0d expected 0", cnt); end
    n_checks++; if (clk_out !== 1'b0 || tick !== 1'b0) begin n_fail++; $display("FAIL rs_out: got clk_out=%b tick=%b expected 0 0", clk_out, tick); end
    n_checks++; if (div_pending !== 1'b0) begin n_fail++; $display("FAIL rs_pending: got %b expected 0", div_pending); end
    for (int i = 1; i <= 4; i++) begin
      cyc();
      n_checks++; if (cnt !== 8'(i % 2) || tick !== (i % 2 == 0)) begin n_fail++; $display("FAIL rs_div1[%0d]: got cnt=%0d tick=%b expected cnt=%0d tick=%b", i, cnt, tick, i % 2, (i % 2 == 0)); end
    end
    n_checks++; if (clk_out !== 1'b0) begin n_fail++; $display("FAIL rs_clk_out: got %b expected 0", clk_out); end
  endtask

  // WIDTH=4 (DIV_RESET=2): full-scale divisor 15, then mid-period reset.
  task automatic test_width4();
    reset4 = 1'b0; en4 = 1'b0;
    div_in4 = 4'd15; div_load4 = 1'b1;
    cyc();
    div_load4 = 1'b0;
    n_checks++; if (div_pending4 !== 1'b1) begin n_fail++; $display("FAIL w4_pending: got %b expected 1", div_pending4); end
    en4 = 1'b1;
    cyc(); cyc(); cyc();
    n_checks++; if (cnt4 !== 4'd0 || tick4 !== 1'b1 || clk_out4 !== 1'b1 || div_pending4 !== 1'b0) begin n_fail++; $display("FAIL w4_wrap2: got cnt=%0d tick=%b clk=%b pend=%b expected 0 1 1 0", cnt4, tick4, clk_out4, div_pending4); end
    for (int i = 1; i <= 15; i++) begin
      cyc();
      n_checks++; if (cnt4 !== 4'(i) || tick4 !== 1'b0) begin n_fail++; $display("FAIL w4_cnt[%0d]: got cnt=%0d tick=%b expected cnt=%0d tick=0", i, cnt4, tick4, i); end
    end
    cyc();
    n_checks++; if (cnt4 !== 4'd0 || tick4 !== 1'b1 || clk_out4 !== 1'b0) begin n_fail++; $display("FAIL w4_wrap15: got cnt=%0d tick=%b clk=%b expected 0 1 0", cnt4, tick4, clk_out4); end
    repeat (5) cyc();
    n_checks++; if (cnt4 !== 4'd5) begin n_fail++; $display("FAIL w4_mid: got %0d expected 5", cnt4); end
    reset4 = 1'b1; restart4 = 1'b1; div_in4 = 4'd9; div_load4 = 1'b1;
    cyc();
    reset4 = 1'b0; restart4 = 1'b0; div_load4 = 1'b0;
    n_checks++; if (cnt4 !== 4'd0 || tick4 !== 1'b0 || clk_out4 !== 1'b0 || div_pending4 !== 1'b0) begin n_fail++; $display("FAIL w4_reset: got cnt=%0d tick=%b clk=%b pend=%b expected 0 0 0 0", cnt4, tick4, clk_out4, div_pending4); end
    cyc(); cyc(); cyc();
    n_checks++; if (cnt4 !== 4'd0 || tick4 !== 1'b1 || clk_out4 !== 1'b1) begin n_fail++; $display("FAIL w4_divreset: got cnt=%0d tick=%b clk=%b expected 0 1 1", cnt4, tick4, clk_out4); end
  endtask

  initial begin
    test_reset();
    test_div_zero();
    test_load_pending();
    test_enable_hold();
    test_load_on_wrap();
    test_restart();
    test_width4();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
